// File: rtl/arbitro_rr4_if.sv
// Bundle of the arbiter's FIFO-side and downstream-side handshake signals.
// master: the arbiter (drives pops, push, data_out, grant, cont_out).
// slave:  the FIFO/downstream side (drives empties, valids, read data, almost-full).
interface arbitro_rr4_if #(
    parameter int DATA_SIZE = 12
);
    logic                 fifo0_empty;
    logic                 fifo1_empty;
    logic                 fifo2_empty;
    logic                 fifo3_empty;
    logic                 fifo0_valid;
    logic                 fifo1_valid;
    logic                 fifo2_valid;
    logic                 fifo3_valid;
    logic [DATA_SIZE-1:0] data_in0;
    logic [DATA_SIZE-1:0] data_in1;
    logic [DATA_SIZE-1:0] data_in2;
    logic [DATA_SIZE-1:0] data_in3;
    logic                 out_almost_full;
    logic                 pop0;
    logic                 pop1;
    logic                 pop2;
    logic                 pop3;
    logic                 push;
    logic [DATA_SIZE-1:0] data_out;
    logic [1:0]           grant;
    logic [4:0]           cont_out;

    modport master (
        input  fifo0_empty, fifo1_empty, fifo2_empty, fifo3_empty,
        input  fifo0_valid, fifo1_valid, fifo2_valid, fifo3_valid,
        input  data_in0, data_in1, data_in2, data_in3,
        input  out_almost_full,
        output pop0, pop1, pop2, pop3,
        output push, data_out, grant, cont_out
    );

    modport slave (
        output fifo0_empty, fifo1_empty, fifo2_empty, fifo3_empty,
        output fifo0_valid, fifo1_valid, fifo2_valid, fifo3_valid,
        output data_in0, data_in1, data_in2, data_in3,
        output out_almost_full,
        input  pop0, pop1, pop2, pop3,
        input  push, data_out, grant, cont_out
    );
endinterface

// File: rtl/arbitro_rr4.sv
// Four-to-one round-robin output arbiter. Drains four per-class FIFOs into one
// downstream FIFO, up to BURST pops per grant, with one IDLE cycle between
// grants. Pops are combinational; push/data_out/grant/cont_out are registered.
module arbitro_rr4 #(
    parameter int DATA_SIZE = 12,
    parameter int BURST     = 4
) (
    input  logic           clk,
    input  logic           reset_L,
    arbitro_rr4_if.master  bus
);
    typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

    localparam logic [2:0] LAST = 3'(BURST - 1);

    state_t               state;
    logic [1:0]           ptr;
    logic [1:0]           grant_r;
    logic [2:0]           burst_cnt;
    logic [3:0]           empty_v;
    logic [3:0]           valid_v;
    logic [3:0]           pop_v;
    logic                 pop_any;
    logic                 full;
    logic [1:0]           sel;
    logic                 sel_ok;
    logic [1:0]           cand;
    logic [DATA_SIZE-1:0] vdata;
    logic                 push_r;
    logic [DATA_SIZE-1:0] data_r;
    logic [4:0]           cont_r;

    assign empty_v = {bus.fifo3_empty, bus.fifo2_empty, bus.fifo1_empty, bus.fifo0_empty};
    assign valid_v = {bus.fifo3_valid, bus.fifo2_valid, bus.fifo1_valid, bus.fifo0_valid};
    assign full    = bus.out_almost_full;

    // First non-empty queue scanning ptr, ptr+1, ptr+2, ptr+3; the smallest
    // offset is visited last so it wins.
    always_comb begin
        sel    = 2'd0;
        sel_ok = 1'b0;
        cand   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (!empty_v[cand]) begin
                sel    = cand;
                sel_ok = 1'b1;
            end
        end
    end

    // Mealy pop: only the granted queue, only when it has data and room exists downstream.
    always_comb begin
        pop_v = 4'b0000;
        if (state == SERVE && !empty_v[grant_r] && !full) begin
            pop_v[grant_r] = 1'b1;
        end
    end

    assign pop_any  = |pop_v;
    assign bus.pop0 = pop_v[0];
    assign bus.pop1 = pop_v[1];
    assign bus.pop2 = pop_v[2];
    assign bus.pop3 = pop_v[3];

    // Grant FSM: IDLE picks the next queue, SERVE bursts until BURST pops or the queue drains.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            grant_r   <= 2'd0;
            burst_cnt <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_ok && !full) begin
                        grant_r   <= sel;
                        burst_cnt <= 3'd0;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (empty_v[grant_r]) begin
                        state <= IDLE;
                        ptr   <= grant_r + 2'd1;
                    end else if (pop_any) begin
                        burst_cnt <= burst_cnt + 3'd1;
                        if (burst_cnt == LAST) begin
                            state <= IDLE;
                            ptr   <= grant_r + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-data select; at most one valid is high since only one pop is issued per cycle.
    always_comb begin
        vdata = bus.data_in0;
        if (valid_v[1]) vdata = bus.data_in1;
        if (valid_v[2]) vdata = bus.data_in2;
        if (valid_v[3]) vdata = bus.data_in3;
    end

    // Registered forward of each returned word with a running push count.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push_r <= 1'b0;
            data_r <= '0;
            cont_r <= 5'd0;
        end else if (|valid_v) begin
            push_r <= 1'b1;
            data_r <= vdata;
            cont_r <= cont_r + 5'd1;
        end else begin
            push_r <= 1'b0;
        end
    end

    assign bus.push     = push_r;
    assign bus.data_out = data_r;
    assign bus.grant    = grant_r;
    assign bus.cont_out = cont_r;
endmodule

// File: doc/arbitro_rr4.md
# arbitro_rr4

Four-to-one output arbiter that drains the four per-class output FIFOs (fed by the class-routing arbiter) into a single downstream FIFO. It serves non-empty queues in round-robin order, with up to BURST consecutive pops per grant, honours downstream almost-full backpressure, and forwards each popped word with a registered push.

## Interface
- DATA_SIZE, 12, word width.
- BURST, 4, maximum consecutive pops per grant (range 1..7).

- clk  input  1  system clock, all state updates on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- fifoN_empty (N=0..3)  input  1  empty flag of output FIFO N.
- fifoN_valid (N=0..3)  input  1  FIFO N read data valid, one cycle after its pop.
- data_inN (N=0..3)  input  DATA_SIZE  read data of FIFO N.
- out_almost_full  input  1  almost-full flag of the downstream FIFO.
- popN (N=0..3)  output  1  read strobe to FIFO N. Combinational (Mealy).
- push  output  DATA_SIZE-independent 1  write strobe to downstream FIFO. Registered.
- data_out  output  DATA_SIZE  word to downstream FIFO. Registered.
- grant  output  2  queue currently served. Registered.
- cont_out  output  5  count of words pushed, mod 32.

## Operation
- State registers: state {IDLE, SERVE}, ptr[1:0], grant[1:0], burst_cnt[2:0].
- IDLE:
  - All popN = 0.
  - If out_almost_full = 0 and any fifoN_empty = 0: select the first non-empty queue in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On a selection: grant <= selected queue, burst_cnt <= 0, state <= SERVE.
  - Otherwise: remain in IDLE.
- SERVE:
  - pop[grant] = !fifo[grant]_empty && !out_almost_full. All other pops are 0.
  - Each pop increments burst_cnt.
  - Exit to IDLE, with ptr <= grant+1 (mod 4), when either condition holds:
    - a pop occurs with burst_cnt == BURST-1;
    - fifo[grant]_empty = 1 in SERVE.
  - If out_almost_full = 1 and the queue is not empty: stay in SERVE with no pop; burst_cnt is frozen.
- Data path:
  - When any fifoN_valid = 1 at an edge: data_out <= data_inN, push <= 1, cont_out <= cont_out + 1 (31 wraps to 0).
  - Otherwise push <= 0 and data_out holds its value.
  - At most one valid is high per cycle, because only one pop is issued per cycle.
- At most one popN is high in any cycle. A queue that is empty is never popped.
- Every queue switch costs one IDLE cycle with no pop.

## Timing
- Reset (reset_L = 0, asynchronous): state = IDLE, ptr = 0, grant = 0, burst_cnt = 0, push = 0, data_out = 0, cont_out = 0, all popN = 0 immediately.
- Any word still in flight when reset asserts is dropped; the FIFOs reset on the same signal.
- Latency: pop at cycle t, fifoN_valid/data_inN at t+1, push/data_out at t+2.
- Steady state: BURST consecutive pops per grant, then one IDLE cycle.
- Backpressure: pops stop in the same cycle out_almost_full rises. At most 2 further pushes follow (words in flight), so the downstream almost-full threshold must leave at least 2 free entries.
- Reset release: the first pop occurs no earlier than the second edge after reset_L rises (IDLE, then SERVE).

## Test plan
- Reset: hold reset_L = 0 with fifo0 non-empty -> all popN, push, data_out, cont_out, grant = 0. Assert reset_L mid-burst -> outputs clear without waiting for a clock edge.
- Single queue: FIFO1 holds 0x101, 0x102, 0x103 -> one IDLE cycle, then pop1 for 3 consecutive cycles. push carries 0x101, 0x102, 0x103 two cycles after each pop; cont_out = 3; ptr = 2.
- Round robin, BURST = 4, six words in every queue -> grant sequence 0×4, 1×4, 2×4, 3×4, 0×2, 1×2, 2×2, 3×2 words. Never two pops in one cycle; cont_out = 24.
- Backpressure: raise out_almost_full after the 2nd pop of a queue-0 burst, for 3 cycles -> no popN during those cycles, at most 2 pushes. After release, 2 more pop0 complete the burst before rotation to queue 1.
- Skip empty: only FIFO3 and FIFO0 non-empty, ptr = 1 -> queue 3 is served first, then queue 0.
- Counter wrap: push 33 words total -> cont_out = 1; data order preserved per queue.
